// File: rtl/div_clock_counter_pkg.sv
// Shared types and helpers for div_clock_counter and its prescaler.
package div_clock_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

    localparam int unsigned RATIO_W = 32;

    // A ratio of zero behaves like one: tick on every enabled cycle.
    function automatic logic [RATIO_W-1:0] eff_ratio(input logic [RATIO_W-1:0] ratio);
        return (ratio == '0) ? RATIO_W'(1) : ratio;
    endfunction

endpackage

// File: rtl/div_clock_counter_clk_prescaler.sv
// Programmable prescaler: emits a one-cycle advance strobe every R enabled cycles.
module clk_prescaler
    import div_clock_counter_pkg::*;
#(
    parameter int unsigned DIV_BITS    = 16,
    parameter int unsigned DIV_DEFAULT = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic                load,
    input  logic [DIV_BITS-1:0] ratio,
    output logic                tick
);

    logic [DIV_BITS-1:0] count_q;
    logic [DIV_BITS-1:0] ratio_q;
    logic [RATIO_W-1:0]  r_eff;
    logic                at_end;

    // tick is the pre-register strobe; the parent registers it alongside the counter.
    always_comb begin
        r_eff  = eff_ratio(RATIO_W'(ratio_q));
        at_end = (RATIO_W'(count_q) == (r_eff - RATIO_W'(1)));
        tick   = enable && !clear && !load && at_end;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ratio_q <= DIV_BITS'(DIV_DEFAULT);
        end else begin
            if (clear || load) begin
                count_q <= '0;
            end else if (enable) begin
                count_q <= at_end ? '0 : count_q + DIV_BITS'(1);
            end
            if (load) begin
                ratio_q <= ratio;
            end
        end
    end

endmodule

// File: rtl/div_clock_counter.sv
// Tick counter with programmable prescaler, wrap flag and divided clock.
// Optional capture register enabled by defining DIV_CLOCK_COUNTER_CAPTURE_EN.
module div_clock_counter
    import div_clock_counter_pkg::*;
#(
    parameter int unsigned COUNTER_BITS = 8,
    parameter int unsigned DIV_BITS     = 16,
    parameter int unsigned DIV_DEFAULT  = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    div_load,
    input  logic [DIV_BITS-1:0]     div_ratio,
    input  logic                    count_down,
    output logic [COUNTER_BITS-1:0] counter_out,
    output logic                    tick,
    output logic                    wrap,
    output logic                    clk_div_out
`ifdef DIV_CLOCK_COUNTER_CAPTURE_EN
    ,
    input  logic                    capture,
    output logic [COUNTER_BITS-1:0] capture_out,
    output logic                    capture_valid
`endif
);

    logic                    adv;
    logic [COUNTER_BITS-1:0] count_next;
    logic                    wrap_next;

    clk_prescaler #(
        .DIV_BITS    (DIV_BITS),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .load    (div_load),
        .ratio   (div_ratio),
        .tick    (adv)
    );

    always_comb begin
        count_next = counter_out;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (adv) begin
            if (count_down == DIR_DOWN) begin
                count_next = counter_out - COUNTER_BITS'(1);
                wrap_next  = (counter_out == '0);
            end else begin
                count_next = counter_out + COUNTER_BITS'(1);
                wrap_next  = (counter_out == '1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_out <= '0;
            tick        <= 1'b0;
            wrap        <= 1'b0;
            clk_div_out <= 1'b0;
        end else begin
            counter_out <= count_next;
            tick        <= adv;
            wrap        <= wrap_next;
            if (adv) begin
                clk_div_out <= ~clk_div_out;
            end
        end
    end

`ifdef DIV_CLOCK_COUNTER_CAPTURE_EN
    // Captures the post-update value so a capture on a tick edge sees the new count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_out   <= '0;
            capture_valid <= 1'b0;
        end else if (clear) begin
            capture_valid <= 1'b0;
        end else if (capture) begin
            capture_out   <= count_next;
            capture_valid <= 1'b1;
        end
    end
`endif

endmodule
